// File: rtl/hamming_secded_decoder.sv
// ---------------------------------------------------------------------------
// hamming_secded_decoder
//   Two-stage valid/ready SECDED decoder for 13-bit words produced by the
//   8-bit Hamming encoder. Stage 1 registers the code word, its syndrome and
//   its overall parity. Stage 2 registers the classified result and the
//   corrected data. Two saturating counters track how many single-error and
//   double-error words were handed downstream.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake for code_in
//   code_in[12:0]           {p0,d7,d6,d5,d4,p8,d3,d2,d1,p4,d0,p2,p1}
//   out_valid/out_ready     downstream handshake for data_out and status
//   data_out[7:0]           corrected data (raw data on a double error)
//   err_single, err_double  error classification (never both set)
//   err_pos[3:0]            flipped position 1..12, 13 for p0, 0 otherwise
//   clr_counts              synchronous clear of both counters
//   sec_count, ded_count    saturating single/double error counters
// ---------------------------------------------------------------------------
module hamming_secded_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       data_out,
  output logic             err_single,
  output logic             err_double,
  output logic [3:0]       err_pos,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Syndrome bit i covers every Hamming position k (1..12) with k[i]=1;
  // position k lives in code bit k-1, so the masks are shifted down by one.
  function automatic logic [3:0] calc_syndrome(input logic [12:0] code);
    logic [3:0] syn;
    syn[0] = ^(code[11:0] & 12'h555);
    syn[1] = ^(code[11:0] & 12'h666);
    syn[2] = ^(code[11:0] & 12'h878);
    syn[3] = ^(code[11:0] & 12'hF80);
    return syn;
  endfunction

  // Overall parity across all 13 bits including p0.
  function automatic logic calc_parity(input logic [12:0] code);
    return ^code;
  endfunction

  // Data bits sit at Hamming positions 3,5,6,7,9,10,11,12.
  function automatic logic [7:0] extract_data(input logic [11:0] code);
    return {code[11], code[10], code[9], code[8],
            code[6],  code[5],  code[4], code[2]};
  endfunction

  // Stage 1 state
  logic        v1_r;
  logic [12:0] code1_r;
  logic [3:0]  syn1_r;
  logic        pc1_r;

  // Stage 2 state (drives the outputs directly)
  logic        v2_r;
  logic [7:0]  data2_r;
  logic        single2_r;
  logic        double2_r;
  logic [3:0]  pos2_r;

  logic [CNT_W-1:0] sec_cnt_r;
  logic [CNT_W-1:0] ded_cnt_r;

  logic        ready1_s;
  logic        ready2_s;
  logic        out_fire_s;
  logic [11:0] flip_s;
  logic [11:0] corr_s;
  logic [7:0]  cls_data_s;
  logic        cls_single_s;
  logic        cls_double_s;
  logic [3:0]  cls_pos_s;

  // A stage may load when it is empty or its contents move on this cycle.
  assign ready2_s   = !v2_r || out_ready;
  assign ready1_s   = !v1_r || ready2_s;
  assign out_fire_s = v2_r && out_ready;

  // Stage 1 valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
    end else if (ready1_s) begin
      v1_r <= in_valid;
    end else begin
      v1_r <= v1_r;
    end
  end

  // Stage 1 payload: code word plus its syndrome and overall parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code1_r <= 13'd0;
      syn1_r  <= 4'd0;
      pc1_r   <= 1'b0;
    end else if (ready1_s && in_valid) begin
      code1_r <= code_in;
      syn1_r  <= calc_syndrome(code_in);
      pc1_r   <= calc_parity(code_in);
    end else begin
      code1_r <= code1_r;
      syn1_r  <= syn1_r;
      pc1_r   <= pc1_r;
    end
  end

  // Classify the stage 1 word and build the corrected data.
  always_comb begin
    cls_single_s = 1'b0;
    cls_double_s = 1'b0;
    cls_pos_s    = 4'd0;
    flip_s       = 12'd1 << (syn1_r - 4'd1);
    corr_s       = code1_r[11:0];
    if (!pc1_r) begin
      if (syn1_r == 4'd0) begin
        cls_double_s = 1'b0;
      end else begin
        // Even overall parity with a non-zero syndrome: two bits flipped.
        cls_double_s = 1'b1;
      end
    end else begin
      if (syn1_r == 4'd0) begin
        // Only p0 disagrees; the data bits are intact.
        cls_single_s = 1'b1;
        cls_pos_s    = 4'd13;
      end else if (syn1_r <= 4'd12) begin
        cls_single_s = 1'b1;
        cls_pos_s    = syn1_r;
        corr_s       = code1_r[11:0] ^ flip_s;
      end else begin
        // Syndrome points past the last position: not a single-bit error.
        cls_double_s = 1'b1;
      end
    end
    cls_data_s = extract_data(corr_s);
  end

  // Stage 2 valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r <= 1'b0;
    end else if (ready2_s) begin
      v2_r <= v1_r;
    end else begin
      v2_r <= v2_r;
    end
  end

  // Stage 2 payload: registered result, held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data2_r   <= 8'd0;
      single2_r <= 1'b0;
      double2_r <= 1'b0;
      pos2_r    <= 4'd0;
    end else if (ready2_s && v1_r) begin
      data2_r   <= cls_data_s;
      single2_r <= cls_single_s;
      double2_r <= cls_double_s;
      pos2_r    <= cls_pos_s;
    end else begin
      data2_r   <= data2_r;
      single2_r <= single2_r;
      double2_r <= double2_r;
      pos2_r    <= pos2_r;
    end
  end

  // Single-error counter: clear wins, otherwise count delivered SEC words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_counts) begin
      sec_cnt_r <= {CNT_W{1'b0}};
    end else if (out_fire_s && single2_r && (sec_cnt_r != CNT_MAX)) begin
      sec_cnt_r <= sec_cnt_r + CNT_ONE;
    end else begin
      sec_cnt_r <= sec_cnt_r;
    end
  end

  // Double-error counter: clear wins, otherwise count delivered DED words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ded_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_counts) begin
      ded_cnt_r <= {CNT_W{1'b0}};
    end else if (out_fire_s && double2_r && (ded_cnt_r != CNT_MAX)) begin
      ded_cnt_r <= ded_cnt_r + CNT_ONE;
    end else begin
      ded_cnt_r <= ded_cnt_r;
    end
  end

  assign in_ready   = ready1_s;
  assign out_valid  = v2_r;
  assign data_out   = data2_r;
  assign err_single = single2_r;
  assign err_double = double2_r;
  assign err_pos    = pos2_r;
  assign sec_count  = sec_cnt_r;
  assign ded_count  = ded_cnt_r;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming_secded_decoder
//   Directed bench for hamming_secded_decoder: reset values, latency, a table
//   of hand-encoded words, a backpressured stream, counter saturation/clear
//   and reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_hamming_secded_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] code_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        err_single;
  logic        err_double;
  logic [3:0]  err_pos;
  logic        clr_counts;
  logic [7:0]  sec_count;
  logic [7:0]  ded_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_sec      = 0;
  int exp_ded      = 0;

  // Hand-encoded words: 0xAF encodes to 0x1A75, 0xFF to 0x0F77, 0x00 to 0x0000.
  logic [12:0] tbl_code   [0:8] = '{13'h0000, 13'h1A75, 13'h0F77, 13'h1A65, 13'h0A75,
                                    13'h1A76, 13'h1AFC, 13'h0777, 13'h0080};
  logic [7:0]  tbl_data   [0:8] = '{8'h00, 8'hAF, 8'hFF, 8'hAF, 8'hAF,
                                    8'hAF, 8'hAF, 8'hFF, 8'h00};
  logic        tbl_single [0:8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        tbl_double [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [3:0]  tbl_pos    [0:8] = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd13, 4'd0, 4'd0, 4'd12, 4'd8};

  hamming_secded_decoder #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code_in    (code_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .err_single (err_single),
    .err_double (err_double),
    .err_pos    (err_pos),
    .clr_counts (clr_counts),
    .sec_count  (sec_count),
    .ded_count  (ded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One word through an idle pipeline with out_ready held high.
  task automatic run_one(input int idx);
    in_valid  = 1'b1;
    code_in   = tbl_code[idx];
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_value("lat1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_value("lat2_valid", 32'(out_valid), 32'd1);
    check_value("data", 32'(data_out), 32'(tbl_data[idx]));
    check_value("err_single", 32'(err_single), 32'(tbl_single[idx]));
    check_value("err_double", 32'(err_double), 32'(tbl_double[idx]));
    check_value("err_pos", 32'(err_pos), 32'(tbl_pos[idx]));
    exp_sec += int'(tbl_single[idx]);
    exp_ded += int'(tbl_double[idx]);
    @(posedge clk); #1;
    check_value("drained", 32'(out_valid), 32'd0);
    check_value("sec_count", 32'(sec_count), 32'(exp_sec));
    check_value("ded_count", 32'(ded_count), 32'(exp_ded));
  endtask

  // Back-to-back words with random backpressure; checks order, values, hold.
  task automatic stream_test();
    int         n_words = 27;
    int         sent    = 0;
    int         recv    = 0;
    int         cyc     = 0;
    logic       stalled = 1'b0;
    logic [7:0] h_data  = 8'd0;
    logic       h_sgl   = 1'b0;
    logic       h_dbl   = 1'b0;
    logic [3:0] h_pos   = 4'd0;
    while (recv < n_words && cyc < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < n_words) begin
        in_valid = 1'b1;
        code_in  = tbl_code[sent % 9];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        check_value("hold_valid", 32'(out_valid), 32'd1);
        check_value("hold_data", 32'(data_out), 32'(h_data));
        check_value("hold_flags", 32'({err_single, err_double, err_pos}),
                    32'({h_sgl, h_dbl, h_pos}));
      end
      if (out_valid) begin
        if (out_ready) begin
          check_value("stream_data", 32'(data_out), 32'(tbl_data[recv % 9]));
          check_value("stream_flags", 32'({err_single, err_double, err_pos}),
                      32'({tbl_single[recv % 9], tbl_double[recv % 9], tbl_pos[recv % 9]}));
          exp_sec += int'(tbl_single[recv % 9]);
          exp_ded += int'(tbl_double[recv % 9]);
          recv++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_data  = data_out;
          h_sgl   = err_single;
          h_dbl   = err_double;
          h_pos   = err_pos;
        end
      end else begin
        stalled = 1'b0;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_value("stream_recv", 32'(recv), 32'(n_words));
    check_value("stream_sec", 32'(sec_count), 32'(exp_sec));
    check_value("stream_ded", 32'(ded_count), 32'(exp_ded));
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    code_in    = 13'd0;
    out_ready  = 1'b0;
    clr_counts = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_out_valid", 32'(out_valid), 32'd0);
    check_value("rst_data", 32'(data_out), 32'd0);
    check_value("rst_flags", 32'({err_single, err_double, err_pos}), 32'd0);
    check_value("rst_sec", 32'(sec_count), 32'd0);
    check_value("rst_ded", 32'(ded_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_value("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_one(i);

    stream_test();

    // Counter saturation: clear, then 300 single-error words.
    out_ready  = 1'b1;
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    check_value("clr_sec", 32'(sec_count), 32'd0);
    check_value("clr_ded", 32'(ded_count), 32'd0);
    in_valid = 1'b1;
    code_in  = 13'h1A65;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("sat_sec", 32'(sec_count), 32'd255);
    check_value("sat_ded", 32'(ded_count), 32'd0);

    // Clear on the same cycle as an erroring output handshake.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 13'h1A76;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_value("clr_pre_valid", 32'(out_valid), 32'd1);
    check_value("clr_pre_double", 32'(err_double), 32'd1);
    out_ready  = 1'b1;
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    check_value("clr_win_sec", 32'(sec_count), 32'd0);
    check_value("clr_win_ded", 32'(ded_count), 32'd0);
    check_value("clr_drained", 32'(out_valid), 32'd0);

    // Reset with both stages full and the output stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 13'h0F77;
    @(posedge clk); #1;
    code_in = 13'h1A75;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_value("full_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("rst_async_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_value("no_stale_word", 32'(out_valid), 32'd0);
    end
    exp_sec = 0;
    exp_ded = 0;
    run_one(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
